// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - shared codes and helpers for the instruction encoder
// Purpose: format codes, drop-cause codes, base opcodes and immediate
//          range helpers used by the encoder and its immediate packer.
// Ports:   none (package).
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_RSV   = 3'd7
  } fmt_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_FMT   = 3'd3;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;

  // True when v is a two's complement value that fits in n+1 bits,
  // i.e. every bit from position n upward is a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = $signed(v) >>> n;
    return (t == '0) || (t == '1);
  endfunction

  // True when v is a non-negative value below 2**n.
  function automatic logic fits_unsigned(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v >> n;
    return (t == '0);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - field-bundle input and encoded-word output streams
// Purpose: groups the valid/ready input bundle and output word stream.
// Ports:   master = producer of bundles / consumer of words (sequencer side)
//          slave  = the encoder
interface inst_encoder_if #(
  parameter int FMT_W  = 3,
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [FMT_W-1:0]  fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              sext;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, sext,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, sext,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_encoder_imm_pack.sv
// rtl/inst_encoder_imm_pack.sv - places immediate bits and checks their range
// Purpose: combinational immediate scatter for every format plus range and
//          alignment verdicts.
// Ports:   fmt      in  format code
//          imm      in  byte-level immediate
//          sext     in  signed (1) / unsigned (0) check for I and B
//          imm_bits out instruction word with only immediate bits populated
//          range_ok out immediate fits the format
//          align_ok out immediate meets the 2-byte alignment of B/J
module imm_pack
  import inst_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [31:0] imm,
  input  logic        sext,
  output logic [31:0] imm_bits,
  output logic        range_ok,
  output logic        align_ok
);

  always_comb begin
    imm_bits = '0;
    range_ok = 1'b1;
    align_ok = 1'b1;
    unique case (fmt)
      FMT_I: begin
        imm_bits[31:20] = imm[11:0];
        range_ok = sext ? fits_signed(imm, 11) : fits_unsigned(imm, 12);
      end
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_ok = fits_signed(imm, 11);
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[7]     = imm[11];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        // The odd upper bound (4095 / 8191) is caught by alignment first.
        range_ok = sext ? fits_signed(imm, 12) : fits_unsigned(imm, 13);
        align_ok = ~imm[0];
      end
      FMT_U: begin
        imm_bits[31:12] = imm[31:12];
        range_ok = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[19:12] = imm[19:12];
        imm_bits[20]    = imm[11];
        imm_bits[30:21] = imm[10:1];
        range_ok = fits_signed(imm, 20);
        align_ok = ~imm[0];
      end
      FMT_SHIFT: begin
        imm_bits[24:20] = imm[4:0];
        range_ok = fits_unsigned(imm, 5);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - two-stage streaming RISC-V instruction encoder
// Purpose: captures a decoded field bundle (S1), checks and packs it, and
//          presents the encoded word with its byte address (S2).
// Ports:   clock, reset       clock and synchronous active-high reset
//          bus (slave)        input bundle stream and output word stream
//          load_base/base_addr one-cycle pulse reloading the address counter
//          err                one-cycle pulse when a bundle is dropped
//          err_code           sticky cause of the most recent drop
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int FMT_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  inst_encoder_if.slave     bus,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              err,
  output logic [2:0]        err_code
);

  logic              s1_valid;
  fmt_e              s1_fmt;
  logic [6:0]        s1_opcode;
  logic [2:0]        s1_funct3;
  logic [6:0]        s1_funct7;
  logic [4:0]        s1_rd;
  logic [4:0]        s1_rs1;
  logic [4:0]        s1_rs2;
  logic [31:0]       s1_imm;
  logic              s1_sext;

  logic              s2_valid;
  logic [31:0]       s2_inst;
  logic [ADDR_W-1:0] s2_addr;
  logic [ADDR_W-1:0] addr_cnt;

  logic              s2_free;
  logic              in_fire;
  logic              out_fire;
  logic              s1_move;
  logic [31:0]       imm_bits;
  logic              range_ok;
  logic              align_ok;
  logic [2:0]        drop_code;
  logic [31:0]       reg_bits;
  logic [31:0]       enc_word;
  logic [ADDR_W-1:0] next_addr;

  assign s2_free      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid && bus.out_ready;
  assign s1_move      = s1_valid && s2_free;

  assign bus.out_valid = s2_valid;
  assign bus.out_inst  = s2_inst;
  assign bus.out_addr  = s2_addr;

  imm_pack u_imm_pack (
    .fmt      (s1_fmt),
    .imm      (s1_imm),
    .sext     (s1_sext),
    .imm_bits (imm_bits),
    .range_ok (range_ok),
    .align_ok (align_ok)
  );

  // Misalignment outranks range so an odd branch offset reports as misaligned.
  always_comb begin
    drop_code = ERR_NONE;
    if (s1_fmt == FMT_RSV)  drop_code = ERR_FMT;
    else if (!align_ok)     drop_code = ERR_ALIGN;
    else if (!range_ok)     drop_code = ERR_RANGE;
  end

  // Register-number and funct fields, positioned by format.
  always_comb begin
    reg_bits = '0;
    unique case (s1_fmt)
      FMT_R:        reg_bits = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, 7'd0};
      FMT_I:        reg_bits = {12'd0, s1_rs1, s1_funct3, s1_rd, 7'd0};
      FMT_S, FMT_B: reg_bits = {7'd0, s1_rs2, s1_rs1, s1_funct3, 5'd0, 7'd0};
      FMT_U, FMT_J: reg_bits = {20'd0, s1_rd, 7'd0};
      FMT_SHIFT:    reg_bits = {s1_funct7, 5'd0, s1_rs1, s1_funct3, s1_rd, 7'd0};
      default:      reg_bits = '0;
    endcase
  end

  assign enc_word = reg_bits | imm_bits | {25'd0, s1_opcode};

  // The counter always holds the address of the word at the head of the
  // output (or of the next word to enter S2). A word moving into S2 in the
  // same cycle the current head leaves takes the advanced value; a reload
  // overrides both so that word starts the new region.
  assign next_addr = load_base ? base_addr
                   : out_fire  ? addr_cnt + ADDR_W'(4)
                   :             addr_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_inst  <= '0;
      s2_addr  <= '0;
      addr_cnt <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      addr_cnt <= next_addr;
      err      <= 1'b0;

      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_fmt    <= fmt_e'(bus.fmt);
        s1_opcode <= bus.opcode;
        s1_funct3 <= bus.funct3;
        s1_funct7 <= bus.funct7;
        s1_rd     <= bus.rd;
        s1_rs1    <= bus.rs1;
        s1_rs2    <= bus.rs2;
        s1_imm    <= bus.imm;
        s1_sext   <= bus.sext;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      if (s1_move && drop_code == ERR_NONE) begin
        s2_valid <= 1'b1;
        s2_inst  <= enc_word;
        s2_addr  <= next_addr;
      end else if (out_fire) begin
        s2_valid <= 1'b0;
      end

      if (s1_move && drop_code != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= drop_code;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed scoreboard bench for inst_encoder
module tb_inst_encoder;
  import inst_enc_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_base;
  logic [31:0] base_addr;
  logic        err;
  logic [2:0]  err_code;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  int          n_asserts = 0;
  int          n_fail = 0;

  inst_encoder_if #(.FMT_W(3), .ADDR_W(32)) bus ();

  inst_encoder #(.FMT_W(3), .ADDR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .load_base (load_base),
    .base_addr (base_addr),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Standard RISC-V R-type layout.
  function automatic logic [31:0] r_word(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one bundle until accepted; good bundles are queued with the
  // address the bench expects them to carry.
  task automatic send(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic sext,
                      input logic good, input logic [31:0] exp_inst);
    logic ok;
    bus.fmt = fmt; bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm; bus.sext = sext;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", ok, 1);
    if (ok && good) begin
      sb.push_back('{exp_inst, exp_addr});
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    send(FMT_R, OP_REG, 3'h0, 7'h00, rd, rs1, rs2, 32'h0, 1'b0, 1'b1, r_word(rd, rs1, rs2));
  endtask

  // Bundle that must be dropped with the given cause.
  task automatic send_bad(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                          input logic [31:0] imm, input logic sext, input logic [2:0] code);
    send(fmt, opc, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, imm, sext, 1'b0, 32'h0);
    cycles(1);
    check({tag, "_err"}, err, 1);
    check({tag, "_code"}, err_code, code);
    check({tag, "_noout"}, bus.out_valid, 0);
    cycles(1);
    check({tag, "_err_pulse"}, err, 0);
    check({tag, "_code_sticky"}, err_code, code);
  endtask

  task automatic load(input logic [31:0] a);
    load_base = 1'b1;
    base_addr = a;
    @(posedge clock);
    #1;
    load_base = 1'b0;
    exp_addr = a;
  endtask

  // Scoreboard: compare every transferred word against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_asserts++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_word observed=0x%0h expected=none", bus.out_inst);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_inst", bus.out_inst, e.inst);
        check("sb_addr", bus.out_addr, e.addr);
      end
    end
  end

  initial begin
    reset = 1'b1; load_base = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.fmt = '0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0; bus.sext = 1'b0;
    exp_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);

    // addi x1,x0,-1 with latency check, then jal at base+4, beq, lui
    load(32'h0000_0100);
    send(FMT_I, OP_IMM, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFF0_0093);
    check("lat_not_yet", bus.out_valid, 0);
    cycles(1);
    check("lat_valid", bus.out_valid, 1);
    check("lat_inst", bus.out_inst, 32'hFFF0_0093);
    check("lat_addr", bus.out_addr, 32'h0000_0100);
    send(FMT_J, OP_JAL, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 1'b1, 1'b1, 32'h0080_00EF);
    send(FMT_B, OP_BRANCH, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFE00_0EE3);
    send(FMT_U, OP_LUI, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_52B7);
    send(FMT_S, OP_STORE, 3'h2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFE51_2E23);
    send(FMT_SHIFT, OP_IMM, 3'h5, 7'h20, 5'd2, 5'd2, 5'd0, 32'h0000_0005, 1'b0, 1'b1, 32'h4051_5113);
    send(FMT_I, OP_IMM, 3'h6, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0FFF, 1'b0, 1'b1, 32'hFFF0_6093);
    cycles(3);

    // Drops: address must not advance across them
    send_bad("u_low_bits", FMT_U, OP_LUI, 32'h1234_5001, 1'b0, ERR_RANGE);
    send_bad("b_odd", FMT_B, OP_BRANCH, 32'h0000_0003, 1'b1, ERR_ALIGN);
    send_bad("fmt_rsv", FMT_RSV, OP_IMM, 32'h0, 1'b0, ERR_FMT);
    send_bad("i_2048", FMT_I, OP_IMM, 32'h0000_0800, 1'b1, ERR_RANGE);
    send_bad("shamt_32", FMT_SHIFT, OP_IMM, 32'h0000_0020, 1'b0, ERR_RANGE);
    send_r(5'd3, 5'd1, 5'd2);
    cycles(3);

    // Back-to-back under a 5-cycle output stall
    bus.out_ready = 1'b0;
    send_r(5'd4, 5'd4, 5'd5);
    send_r(5'd5, 5'd5, 5'd6);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_head", bus.out_inst, r_word(5'd4, 5'd4, 5'd5));
    cycles(3);
    check("stall_hold_valid", bus.out_valid, 1);
    check("stall_hold_inst", bus.out_inst, r_word(5'd4, 5'd4, 5'd5));
    bus.out_ready = 1'b1;
    send_r(5'd6, 5'd6, 5'd7);
    send_r(5'd7, 5'd7, 5'd8);
    cycles(4);

    // load_base coincident with a transfer
    bus.out_ready = 1'b0;
    send_r(5'd8, 5'd8, 5'd9);
    cycles(1);
    bus.out_ready = 1'b1;
    load(32'h0000_2000);
    send_r(5'd9, 5'd9, 5'd10);
    cycles(3);

    // Counter wrap
    load(32'hFFFF_FFFC);
    send_r(5'd10, 5'd10, 5'd11);
    send_r(5'd11, 5'd11, 5'd12);
    cycles(3);

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send_r(5'd12, 5'd12, 5'd13);
    send_r(5'd13, 5'd13, 5'd14);
    check("pre_rst_full", bus.in_ready, 0);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_err_code", err_code, 0);
    sb.delete();
    exp_addr = '0;
    bus.out_ready = 1'b1;
    send_r(5'd14, 5'd14, 5'd15);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      cycles(1);
    end
    cycles(1);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V instruction encoder: the inverse of the immediate extender. It takes decoded fields (format, opcode, funct, register numbers, 32-bit immediate) and packs them into a 32-bit instruction word. The bit placement exactly mirrors what the single-cycle datapath's extender unpacks. The block sits between a test/boot sequencer and the instruction-memory write port of the sc_computer. Each word is range-checked, tagged with a byte address, and delivered through a valid/ready pipeline.

## Interface
- FMT_W, 3, width of format code
- ADDR_W, 32, width of address counter

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- fmt  in  FMT_W  0=R 1=I 2=S 3=B 4=U 5=J 6=SHIFT 7=reserved
- opcode  in  7  placed in inst[6:0]
- funct3  in  3  inst[14:12] (R/I/S/B/SHIFT)
- funct7  in  7  inst[31:25] (R/SHIFT)
- rd, rs1, rs2  in  5 each  inst[11:7], [19:15], [24:20] where the format uses them
- imm  in  32  byte-level immediate value
- sext  in  1  1 = signed range check for I and B; 0 = unsigned
- load_base  in  1  one-cycle pulse: address counter <= base_addr
- base_addr  in  ADDR_W  start byte address
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts the word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_inst
- err  out  1  one-cycle pulse: a bundle was dropped
- err_code  out  3  sticky cause of the last drop (0 none, 1 range, 2 misaligned, 3 bad fmt)

## Operation
- Bit packing:
  - I: inst[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
  - SHIFT: [24:20]=imm[4:0], [31:25]=funct7.
- Range checks, computed in stage 1:
  - I: sext=1 requires −2048..2047; sext=0 requires 0..4095.
  - S: −2048..2047.
  - B: sext=1 requires −4096..4094; sext=0 requires 0..8190; imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - J: −2^20..2^20−2; imm[0] must be 0.
  - SHIFT: 0..31.
  - R: imm ignored.
- Failing or fmt=7 bundles are dropped at the stage1→stage2 move:
  - err pulses for one cycle and err_code updates.
  - No output is produced and the address does not advance.
  - Misalignment takes priority over range when both fail.
- Address counter advances by 4 on each out_valid & out_ready; it wraps modulo 2^ADDR_W.
- load_base in the same cycle as a transfer: load wins. The counter takes base_addr and the transferred word keeps its old address.

## Timing
- Two-register pipeline, S1 (capture + check) and S2 (output). Latency is 2 cycles from acceptance to out_valid; throughput is 1 word per cycle.
- Stall logic:
  - s2_free = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_free.
  - S1 moves to S2 when s1_valid & s2_free.
  - A dropped S1 entry frees S1 without loading S2.
- out_valid, once high, holds and keeps out_inst/out_addr stable until out_ready. Order is preserved.
- Reset values: s1_valid=0, s2_valid=0, out_inst=0, out_addr=0 (counter 0), err=0, err_code=0. in_ready is 1 in the first cycle after reset.
- Reset mid-stream discards both stages. No partial word is emitted.

## Structure
- Package inst_enc_pkg holds:
  - fmt codes (FMT_R..FMT_RSV)
  - err_code constants
  - opcode constants (OP_IMM, OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_REG)
- One combinational sub-module, imm_pack: fmt, imm, sext → imm field bits, range_ok, align_ok. It is instantiated in S1. The top module holds the pipeline registers, handshake and address counter.

## Test plan
- I-type addi x1,x0,−1 (opcode 0x13, imm 0xFFFFFFFF, sext=1) → out_inst 0xFFF00093 two cycles after acceptance, out_addr = base.
- B-type beq x0,x0,−4 (opcode 0x63, sext=1) → 0xFE000EE3. J-type jal x1,+8 (opcode 0x6F) → 0x008000EF at base+4.
- U-type lui x5, imm 0x12345000 → 0x123452B7. Same with imm 0x12345001 → dropped, err pulse, err_code=1, address unchanged.
- B-type with imm=3 → err_code=2, no output. fmt=7 → err_code=3.
- Back-to-back 4 bundles with out_ready=0 for 5 cycles → in_ready falls after 2 captured. After release, 4 words come out in order at consecutive addresses with no loss or duplication.
- Checks at the boundaries:
  - load_base coincident with a transfer → the next word carries base_addr.
  - Counter at 0xFFFFFFFC wraps to 0.
  - Reset asserted with both stages full → out_valid=0 the next cycle.
